chacha20_byte_packer: RTL
=========================

// Module: chacha20_byte_packer
// PURPOSE
//  Upstream stage of the ChaCha20 encrypt/decrypt cores. Packs an 8-bit byte stream into the
//  32-bit little-endian word stream the cores consume (data/valid/last/ready). A trailing
//  partial word is padded, and a byte-enable (out_keep) is produced so the downstream
//  unpacker can trim the cipher output back to the true message length.
// PARAMETERS
//  PAD_BYTE  8'h00  value written into unused byte lanes of a final partial word
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_data    in   8   input byte
//  in_valid   in   1   in_data valid
//  in_last    in   1   in_data is final byte of message
//  in_ready   out  1   packer accepts byte this cycle
//  out_data   out  32  packed word; first byte of word in [7:0], fourth in [31:24]
//  out_valid  out  1   out_data valid
//  out_last   out  1   out_data is final word of message
//  out_keep   out  4   valid byte lanes: 4'b0001/0011/0111/1111
//  out_ready  in   1   downstream (cipher core plaintext_ready) accepts word
// BEHAVIOUR
//  - Reset (async assert, sync release): out_data=0, out_valid=0, out_last=0, out_keep=0,
//    lane count=0, accumulator=0; in_ready is 1 while rst_n=1 and output register empty.
//  - Byte handshake: in_valid & in_ready at a rising edge. Word handshake: out_valid & out_ready.
//  - in_ready = !out_valid | out_ready (combinational from out_ready; stall only while a word is held).
//  - Lane counter cnt[1:0], FSM: EMPTY (cnt=0) -> FILL (cnt=1..3) -> EMPTY on word emit.
//    Accepted byte is written to lane cnt; cnt increments mod 4.
//  - Emit: when accepted byte lands in lane 3, or has in_last=1, the word (lanes above the
//    byte filled with PAD_BYTE) loads the output register next edge; out_valid=1 one cycle
//    after the completing byte (latency 1). out_keep = lanes 0..cnt set; out_last = in_last.
//    cnt returns to 0; accumulator cleared to PAD_BYTE lanes.
//  - in_last in lane 3: single word with keep=4'b1111, out_last=1; no extra empty word.
//  - Simultaneous word handshake and new word load in same cycle: register takes new word,
//    out_valid stays 1 (full 1-byte/cycle throughput, one word every 4 cycles).
//  - Word handshake without new load: out_valid, out_last, out_keep clear next edge;
//    out_data holds last value.
//  - out_valid=1 & out_ready=0: out_data/out_last/out_keep stable; no byte accepted.
//  - in_last with in_valid=0 ignored. Zero-length messages not representable.
//  - Reset mid-message: partial word discarded; next byte after release goes to lane 0.
// CONFIGURATION
//  CHACHA20_PACKER_COUNT_EN defined: adds ports
//    msg_bytes  out 32  byte count of last completed message (wraps mod 2^32), reset 0
//    msg_done   out 1   one-cycle pulse on the word handshake carrying out_last; msg_bytes
//                       valid from that same cycle until next msg_done
//  Internal running counter clears after each in_last byte. Undefined: ports and counters
//  absent; all other behaviour identical.
// TESTING
//  1. Bytes 01..08, in_last on 08, out_ready=1 -> 32'h04030201 keep F last0; 32'h08070605 keep F last1.
//  2. AA BB CC DD EE, last on EE -> 32'hDDCCBBAA keep F; then 32'h000000EE keep 4'b0001 last1.
//  3. PAD_BYTE=8'hFF, single byte 5A with last -> 32'hFFFFFF5A keep 4'b0001 last1, 1 cycle later.
//  4. out_ready=0 with word held -> in_ready=0, out_data stable 10 cycles; release -> no byte lost/duplicated.
//  5. rst_n low after 2 bytes of 11 22 33 44 -> outputs 0; then 55 66 77 88 -> 32'h88776655.
//  6. COUNT_EN: 6-byte message -> msg_done pulses once with last word, msg_bytes=6; next 4-byte msg -> 4.

Source files
------------

// File: rtl/chacha20_byte_packer.sv
// Packs an 8-bit byte stream into 32-bit little-endian words with a byte-enable, ahead of the ChaCha20 cores.
// Optional feature: define CHACHA20_PACKER_COUNT_EN to add the msg_bytes / msg_done message-length ports.
module chacha20_byte_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic [3:0]  out_keep,
`ifdef CHACHA20_PACKER_COUNT_EN
  output logic [31:0] msg_bytes,
  output logic        msg_done,
`endif
  input  logic        out_ready
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } state_t;

  state_t      state_r;
  logic [1:0]  cnt_r;
  logic [23:0] acc_r;
  logic        accept_s;
  logic        emit_s;
  logic        hs_s;
  logic [31:0] word_s;
  logic [3:0]  keep_s;

  // A byte can only be stalled while a finished word is still waiting downstream.
  assign in_ready = !out_valid | out_ready;

  // Handshake decode and assembly of the candidate word: lanes above the incoming byte are padded.
  always_comb begin
    accept_s = in_valid & in_ready;
    emit_s   = accept_s & ((cnt_r == 2'd3) | in_last);
    hs_s     = out_valid & out_ready;
    word_s   = {PAD_BYTE, PAD_BYTE, PAD_BYTE, PAD_BYTE};
    keep_s   = 4'b0000;
    if (state_r == ST_EMPTY) begin
      word_s[7:0] = in_data;
    end else begin
      word_s[7:0] = acc_r[7:0];
    end
    if (cnt_r > 2'd1) begin
      word_s[15:8] = acc_r[15:8];
    end else if (cnt_r == 2'd1) begin
      word_s[15:8] = in_data;
    end else begin
      word_s[15:8] = PAD_BYTE;
    end
    if (cnt_r == 2'd3) begin
      word_s[23:16] = acc_r[23:16];
      word_s[31:24] = in_data;
    end else if (cnt_r == 2'd2) begin
      word_s[23:16] = in_data;
      word_s[31:24] = PAD_BYTE;
    end else begin
      word_s[23:16] = PAD_BYTE;
      word_s[31:24] = PAD_BYTE;
    end
    case (cnt_r)
      2'd0:    keep_s = 4'b0001;
      2'd1:    keep_s = 4'b0011;
      2'd2:    keep_s = 4'b0111;
      2'd3:    keep_s = 4'b1111;
      default: keep_s = 4'b0000;
    endcase
  end

  // Lane FSM, accumulator and output word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_EMPTY;
      cnt_r     <= 2'd0;
      acc_r     <= 24'h000000;
      out_data  <= 32'h00000000;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_keep  <= 4'b0000;
    end else begin
      if (accept_s) begin
        if (emit_s) begin
          state_r <= ST_EMPTY;
          cnt_r   <= 2'd0;
          acc_r   <= {PAD_BYTE, PAD_BYTE, PAD_BYTE};
        end else begin
          state_r <= ST_FILL;
          cnt_r   <= cnt_r + 2'd1;
          case (cnt_r)
            2'd0:    acc_r[7:0]   <= in_data;
            2'd1:    acc_r[15:8]  <= in_data;
            2'd2:    acc_r[23:16] <= in_data;
            default: acc_r        <= acc_r;
          endcase
        end
      end
      // A new word overrides the clear, so back-to-back words keep out_valid high.
      if (emit_s) begin
        out_data  <= word_s;
        out_valid <= 1'b1;
        out_last  <= in_last;
        out_keep  <= keep_s;
      end else if (hs_s) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_keep  <= 4'b0000;
      end
    end
  end

`ifdef CHACHA20_PACKER_COUNT_EN
  logic [31:0] run_cnt_r;
  logic [31:0] pend_cnt_r;
  logic [31:0] msg_bytes_r;

  assign msg_done  = hs_s & out_last;
  // The pending length travels with the final word so msg_bytes is already correct in the msg_done cycle.
  assign msg_bytes = msg_done ? pend_cnt_r : msg_bytes_r;

  // Running byte count per message and the length of the most recently completed message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_r   <= 32'd0;
      pend_cnt_r  <= 32'd0;
      msg_bytes_r <= 32'd0;
    end else begin
      if (accept_s) begin
        if (in_last) begin
          pend_cnt_r <= run_cnt_r + 32'd1;
          run_cnt_r  <= 32'd0;
        end else begin
          run_cnt_r  <= run_cnt_r + 32'd1;
        end
      end
      if (msg_done) begin
        msg_bytes_r <= pend_cnt_r;
      end
    end
  end
`endif

endmodule
